filter_frame_sequencer: RTL and testbench

- Front-end sequencer for the no-border spatial filter datapath.
- Classifies the incoming data stream (coefficient vs pixel) and sequences coefficient-file loading.
- Tracks row/column position within a frame and drives the row-buffer valid strobe.
- Asserts the filter-function enable only when a full MASK_WIDTH x MASK_WIDTH window lies inside the image, and signals frame completion and protocol errors.

---
 rtl/filter_pkg.sv | 35 +++
 rtl/frame_pos_counter.sv | 78 +++++++
 rtl/filter_frame_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_filter_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// ============================================================================
// Module   : filter_pkg
// Purpose  : Shared constants and types for the spatial filter front-end:
//            data-ID codes, sequencer FSM states, coefficient count helper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package filter_pkg;

  // data_id encodings on the input stream
  localparam int DID_PIX  = 0;
  localparam int DID_COEF = 1;

  // Default mask side and the coefficient count it implies
  localparam int MASK_WIDTH_DEFAULT = 7;

  // Number of coefficients in a square mask of the given side
  function automatic int calc_num_coef(input int mask_width);
    return mask_width * mask_width;
  endfunction

  localparam int NUM_COEF = calc_num_coef(MASK_WIDTH_DEFAULT);

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_COEF = 2'd1,
    READY     = 2'd2,
    STREAM    = 2'd3
  } fseq_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_pos_counter.sv
// ============================================================================
// Module   : frame_pos_counter
// Purpose  : Row/column position tracking for the pixel stream. Holds the
//            position the next accepted pixel will take, wraps columns into
//            rows, flags the last pixel of the frame and registers the
//            reported position plus the full-window enable.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_pos_counter
  import filter_pkg::*;
#(
  parameter int ROW_WIDTH  = 640,
  parameter int COL_WIDTH  = 480,
  parameter int MASK_WIDTH = 7,
  parameter int CNT_BIT    = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  input  logic               clear,
  output logic               last,
  output logic [CNT_BIT-1:0] row_cnt,
  output logic [CNT_BIT-1:0] col_cnt,
  output logic               en_funct
);

  localparam logic [CNT_BIT-1:0] C_COL_LAST  = CNT_BIT'(ROW_WIDTH - 1);
  localparam logic [CNT_BIT-1:0] C_ROW_LAST  = CNT_BIT'(COL_WIDTH - 1);
  localparam logic [CNT_BIT-1:0] C_WIN_START = CNT_BIT'(MASK_WIDTH - 1);
  localparam logic [CNT_BIT-1:0] C_ONE       = CNT_BIT'(1);

  // Position the next accepted pixel will occupy
  logic [CNT_BIT-1:0] pos_row;
  logic [CNT_BIT-1:0] pos_col;
  logic               col_wrap;
  logic               window_ok;

  assign col_wrap  = (pos_col == C_COL_LAST);
  assign last      = col_wrap && (pos_row == C_ROW_LAST);
  assign window_ok = (pos_row >= C_WIN_START) && (pos_col >= C_WIN_START);

  // Advance position on each accepted pixel; report the position just used
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_row  <= '0;
      pos_col  <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      en_funct <= 1'b0;
    end else if (clear) begin
      pos_row  <= '0;
      pos_col  <= '0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      en_funct <= 1'b0;
    end else if (advance) begin
      row_cnt  <= pos_row;
      col_cnt  <= pos_col;
      en_funct <= window_ok;
      if (last) begin
        pos_row <= '0;
        pos_col <= '0;
      end else if (col_wrap) begin
        pos_col <= '0;
        pos_row <= pos_row + C_ONE;
      end else begin
        pos_col <= pos_col + C_ONE;
      end
    end else begin
      en_funct <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/filter_frame_sequencer.sv
// ============================================================================
// Module   : filter_frame_sequencer
// Purpose  : Front-end sequencer for the no-border spatial filter. Splits the
//            input stream into coefficients and pixels, loads the coefficient
//            file, streams pixels into the row buffers with position tracking
//            and flags frame completion and protocol errors.
// Options  : FSEQ_WATCHDOG_EN - adds WDOG_CYCLES and wdog_abort; a stalled
//            frame is abandoned after WDOG_CYCLES idle cycles.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module filter_frame_sequencer
  import filter_pkg::*;
#(
  parameter int DATA_BIT   = 15,
  parameter int DATA_IDBIT = 1,
  parameter int ROW_WIDTH  = 640,
  parameter int COL_WIDTH  = 480,
  parameter int MASK_WIDTH = 7,
  parameter int CNT_BIT    = 10,
  parameter int COFCNT_BIT = 15,
  parameter int PIX_BIT    = 8
`ifdef FSEQ_WATCHDOG_EN
  , parameter int WDOG_CYCLES = 4096
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_in_valid,
  input  logic [DATA_IDBIT-1:0] data_id,
  input  logic [DATA_BIT-1:0]   data_in,
  output logic                  buf_valid,
  output logic [PIX_BIT-1:0]    buf_pix,
  output logic                  cf_wr_en,
  output logic [COFCNT_BIT-1:0] cf_data,
  output logic                  en_funct,
  output logic [CNT_BIT-1:0]    row_cnt,
  output logic [CNT_BIT-1:0]    col_cnt,
  output logic                  coef_ready,
  output logic                  frame_done,
  output logic                  proto_err
`ifdef FSEQ_WATCHDOG_EN
  , output logic                wdog_abort
`endif
);

  localparam int COEF_TOTAL = calc_num_coef(MASK_WIDTH);
  localparam int IDX_BIT    = (COEF_TOTAL > 1) ? $clog2(COEF_TOTAL) : 1;
  localparam logic [IDX_BIT-1:0]    C_IDX_LAST = IDX_BIT'(COEF_TOTAL - 1);
  localparam logic [IDX_BIT-1:0]    C_IDX_ONE  = IDX_BIT'(1);
  localparam logic [DATA_IDBIT-1:0] C_ID_PIX   = DATA_IDBIT'(DID_PIX);
  localparam logic [DATA_IDBIT-1:0] C_ID_COEF  = DATA_IDBIT'(DID_COEF);

  fseq_state_t               state;
  fseq_state_t               state_nxt;
  logic [IDX_BIT-1:0]        coef_idx;
  logic [IDX_BIT-1:0]        coef_idx_nxt;
  logic [IDX_BIT-1:0]        load_idx;
  logic                      cf_wr_en_nxt;
  logic [COFCNT_BIT-1:0]     cf_data_nxt;
  logic                      buf_valid_nxt;
  logic [PIX_BIT-1:0]        buf_pix_nxt;
  logic                      coef_ready_nxt;
  logic                      proto_err_nxt;
  logic                      frame_done_nxt;
  logic                      pix_adv;
  logic                      pos_clear;
  logic                      pos_last;
  logic                      is_coef;
  logic                      is_pix;

`ifdef FSEQ_WATCHDOG_EN
  localparam int WDOG_BIT = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_BIT-1:0] C_WDOG_LAST = WDOG_BIT'(WDOG_CYCLES - 1);
  localparam logic [WDOG_BIT-1:0] C_WDOG_ONE  = WDOG_BIT'(1);

  logic [WDOG_BIT-1:0] idle_cnt;
  logic [WDOG_BIT-1:0] idle_cnt_nxt;
  logic                wdog_abort_nxt;
`endif

  assign is_coef  = data_in_valid && (data_id == C_ID_COEF);
  assign is_pix   = data_in_valid && (data_id == C_ID_PIX);
  // A fresh load (from IDLE or a READY reload) always starts at coefficient 0
  assign load_idx = (state == LOAD_COEF) ? coef_idx : '0;

  // Next-state and next-output decode
  always_comb begin
    state_nxt      = state;
    coef_idx_nxt   = coef_idx;
    cf_wr_en_nxt   = 1'b0;
    cf_data_nxt    = cf_data;
    buf_valid_nxt  = 1'b0;
    buf_pix_nxt    = buf_pix;
    coef_ready_nxt = coef_ready;
    proto_err_nxt  = proto_err;
    frame_done_nxt = 1'b0;
    pix_adv        = 1'b0;
    pos_clear      = 1'b0;
`ifdef FSEQ_WATCHDOG_EN
    idle_cnt_nxt   = '0;
    wdog_abort_nxt = 1'b0;
`endif

    case (state)
      IDLE, LOAD_COEF, READY: begin
        if (is_coef) begin
          cf_wr_en_nxt   = 1'b1;
          cf_data_nxt    = data_in[COFCNT_BIT-1:0];
          coef_ready_nxt = (load_idx == C_IDX_LAST);
          if (load_idx == C_IDX_LAST) begin
            state_nxt    = READY;
            coef_idx_nxt = '0;
          end else begin
            state_nxt    = LOAD_COEF;
            coef_idx_nxt = load_idx + C_IDX_ONE;
          end
        end else if (is_pix) begin
          if (state == READY) begin
            buf_valid_nxt  = 1'b1;
            buf_pix_nxt    = data_in[PIX_BIT-1:0];
            pix_adv        = 1'b1;
            frame_done_nxt = pos_last;
            state_nxt      = pos_last ? READY : STREAM;
          end else begin
            proto_err_nxt = 1'b1;
          end
        end
      end

      STREAM: begin
        if (is_pix) begin
          buf_valid_nxt  = 1'b1;
          buf_pix_nxt    = data_in[PIX_BIT-1:0];
          pix_adv        = 1'b1;
          frame_done_nxt = pos_last;
          state_nxt      = pos_last ? READY : STREAM;
        end else if (is_coef) begin
          // Coefficient file stays untouched while a frame is in flight
          proto_err_nxt = 1'b1;
        end
`ifdef FSEQ_WATCHDOG_EN
        if (!data_in_valid) begin
          if (idle_cnt == C_WDOG_LAST) begin
            wdog_abort_nxt = 1'b1;
            pos_clear      = 1'b1;
            state_nxt      = READY;
          end else begin
            idle_cnt_nxt = idle_cnt + C_WDOG_ONE;
          end
        end
`endif
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      coef_idx   <= '0;
      cf_wr_en   <= 1'b0;
      cf_data    <= '0;
      buf_valid  <= 1'b0;
      buf_pix    <= '0;
      coef_ready <= 1'b0;
      proto_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      coef_idx   <= coef_idx_nxt;
      cf_wr_en   <= cf_wr_en_nxt;
      cf_data    <= cf_data_nxt;
      buf_valid  <= buf_valid_nxt;
      buf_pix    <= buf_pix_nxt;
      coef_ready <= coef_ready_nxt;
      proto_err  <= proto_err_nxt;
      frame_done <= frame_done_nxt;
    end
  end

`ifdef FSEQ_WATCHDOG_EN
  // Idle-cycle counter and abort strobe for stalled frames
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt   <= '0;
      wdog_abort <= 1'b0;
    end else begin
      idle_cnt   <= idle_cnt_nxt;
      wdog_abort <= wdog_abort_nxt;
    end
  end
`endif

  frame_pos_counter #(
    .ROW_WIDTH  (ROW_WIDTH),
    .COL_WIDTH  (COL_WIDTH),
    .MASK_WIDTH (MASK_WIDTH),
    .CNT_BIT    (CNT_BIT)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .advance  (pix_adv),
    .clear    (pos_clear),
    .last     (pos_last),
    .row_cnt  (row_cnt),
    .col_cnt  (col_cnt),
    .en_funct (en_funct)
  );

endmodule

`default_nettype wire

// File: tb/tb_filter_frame_sequencer.sv
// ============================================================================
// Module   : tb_filter_frame_sequencer
// Purpose  : Directed self-checking bench for filter_frame_sequencer with an
//            8x6 image and a 3x3 mask.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_filter_frame_sequencer;

  localparam int ROW_W = 8;
  localparam int COL_W = 6;
  localparam int MASK  = 3;
  localparam int NPIX  = ROW_W * COL_W;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data_in_valid = 1'b0;
  logic [0:0]  data_id = 1'b0;
  logic [14:0] data_in = '0;
  logic        buf_valid;
  logic [7:0]  buf_pix;
  logic        cf_wr_en;
  logic [14:0] cf_data;
  logic        en_funct;
  logic [9:0]  row_cnt;
  logic [9:0]  col_cnt;
  logic        coef_ready;
  logic        frame_done;
  logic        proto_err;
`ifdef FSEQ_WATCHDOG_EN
  logic        wdog_abort;
`endif

  int total = 0;
  int bad   = 0;
  int en_seen;
  int done_seen;

  filter_frame_sequencer #(
    .DATA_BIT   (15),
    .DATA_IDBIT (1),
    .ROW_WIDTH  (ROW_W),
    .COL_WIDTH  (COL_W),
    .MASK_WIDTH (MASK),
    .CNT_BIT    (10),
    .COFCNT_BIT (15),
    .PIX_BIT    (8)
`ifdef FSEQ_WATCHDOG_EN
    , .WDOG_CYCLES (16)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in_valid (data_in_valid),
    .data_id       (data_id),
    .data_in       (data_in),
    .buf_valid     (buf_valid),
    .buf_pix       (buf_pix),
    .cf_wr_en      (cf_wr_en),
    .cf_data       (cf_data),
    .en_funct      (en_funct),
    .row_cnt       (row_cnt),
    .col_cnt       (col_cnt),
    .coef_ready    (coef_ready),
    .frame_done    (frame_done),
    .proto_err     (proto_err)
`ifdef FSEQ_WATCHDOG_EN
    , .wdog_abort  (wdog_abort)
`endif
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present one input beat, then step to just after the capturing edge
  task automatic drive(input logic v, input logic id, input logic [14:0] d);
    data_in_valid = v;
    data_id       = id;
    data_in       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    data_in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bv"},  buf_valid,  0);
    check({tag, "_cw"},  cf_wr_en,   0);
    check({tag, "_en"},  en_funct,   0);
    check({tag, "_fd"},  frame_done, 0);
    check({tag, "_cr"},  coef_ready, 0);
    check({tag, "_pe"},  proto_err,  0);
    check({tag, "_row"}, row_cnt,    0);
    check({tag, "_col"}, col_cnt,    0);
  endtask

  task automatic load_coefs(input int base);
    for (int i = 0; i < MASK * MASK; i++) begin
      drive(1'b1, 1'b1, 15'(base + i));
      check("ld_cw",   cf_wr_en,   1);
      check("ld_data", cf_data,    base + i);
      check("ld_rdy",  coef_ready, (i == MASK * MASK - 1) ? 1 : 0);
    end
    drive(1'b0, 1'b0, '0);
    check("ld_idle_cw", cf_wr_en, 0);
  endtask

  // Stream pixels lo..hi of a frame with optional random idle gaps
  task automatic send_range(input int lo, input int hi, input int max_gap, input logic exp_err);
    int r;
    int c;
    int exp_en;
    int exp_fd;
    logic [14:0] d;
    for (int k = lo; k <= hi; k++) begin
      r = k / ROW_W;
      c = k % ROW_W;
      if (max_gap > 0 && k > lo) begin
        repeat ($urandom_range(0, max_gap)) begin
          drive(1'b0, 1'b0, 15'h5555);
          check("gap_bv",  buf_valid, 0);
          check("gap_en",  en_funct,  0);
          check("gap_row", row_cnt,   (k - 1) / ROW_W);
          check("gap_col", col_cnt,   (k - 1) % ROW_W);
        end
      end
      d = {7'h7F, 8'(k)};
      drive(1'b1, 1'b0, d);
      exp_en = (r >= MASK - 1 && c >= MASK - 1) ? 1 : 0;
      exp_fd = (k == NPIX - 1) ? 1 : 0;
      check("px_bv",  buf_valid,  1);
      check("px_pix", buf_pix,    k & 8'hFF);
      check("px_row", row_cnt,    r);
      check("px_col", col_cnt,    c);
      check("px_en",  en_funct,   exp_en);
      check("px_fd",  frame_done, exp_fd);
      check("px_cw",  cf_wr_en,   0);
      check("px_pe",  proto_err,  exp_err);
      if (en_funct === 1'b1)   en_seen++;
      if (frame_done === 1'b1) done_seen++;
    end
  endtask

  task automatic full_frame(input string tag, input int max_gap, input logic exp_err);
    en_seen = 0;
    done_seen = 0;
    send_range(0, NPIX - 1, max_gap, exp_err);
    check({tag, "_en_total"},   en_seen,   (ROW_W - MASK + 1) * (COL_W - MASK + 1));
    check({tag, "_done_total"}, done_seen, 1);
    drive(1'b0, 1'b0, '0);
    check({tag, "_fd_pulse"}, frame_done, 0);
    check({tag, "_rdy_kept"}, coef_ready, 1);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_all_zero("rst");
    check("rst_pix",  buf_pix, 0);
    check("rst_cf",   cf_data, 0);

    // Coefficient load
    load_coefs(1);
    check("s1_pe", proto_err, 0);

    // Two back-to-back frames, no reload in between
    full_frame("s2a", 0, 1'b0);
    full_frame("s2b", 0, 1'b0);

    // Random idle gaps inside a frame
    full_frame("s4", 2, 1'b0);

    // Protocol errors: pixel in IDLE, coefficient mid-frame
    do_reset();
    drive(1'b1, 1'b0, 15'h0042);
    check("s3_idle_bv", buf_valid, 0);
    check("s3_idle_pe", proto_err, 1);
    load_coefs(20);
    en_seen = 0;
    done_seen = 0;
    send_range(0, 9, 0, 1'b1);
    drive(1'b1, 1'b1, 15'h0123);
    check("s3_mid_cw",  cf_wr_en,  0);
    check("s3_mid_bv",  buf_valid, 0);
    check("s3_mid_cf",  cf_data,   28);
    check("s3_mid_row", row_cnt,   1);
    check("s3_mid_col", col_cnt,   1);
    check("s3_mid_pe",  proto_err, 1);
    send_range(10, NPIX - 1, 0, 1'b1);
    check("s3_done", done_seen, 1);
    drive(1'b0, 1'b0, '0);
    check("s3_pe_sticky", proto_err, 1);
    do_reset();
    check("s3_pe_clr", proto_err, 0);

    // Asynchronous reset in the middle of a frame
    load_coefs(1);
    send_range(0, 19, 0, 1'b0);
    reset = 1'b0;
    #2;
    check_all_zero("s5_async");
    check("s5_state_pix", buf_pix, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, 15'h0011);
    check("s5_rej_bv", buf_valid,  0);
    check("s5_rej_pe", proto_err,  1);
    check("s5_rej_cr", coef_ready, 0);

`ifdef FSEQ_WATCHDOG_EN
    // Watchdog abort after 16 idle cycles mid-frame
    do_reset();
    load_coefs(1);
    en_seen = 0;
    done_seen = 0;
    send_range(0, 9, 0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b0, '0);
      check("s6_wd", wdog_abort, (i == 16) ? 1 : 0);
      check("s6_fd", frame_done, 0);
    end
    drive(1'b0, 1'b0, '0);
    check("s6_wd_pulse", wdog_abort, 0);
    check("s6_rdy",      coef_ready, 1);
    send_range(0, 0, 0, 1'b0);
    check("s6_done", done_seen, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: got=stalled exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
